// File: rtl/misr_trace_capture.sv
// Commit-port tap feeding the MISR: captures a programmed number of commit words
// into a small FIFO and streams them out one per cycle with a matching enable.
module misr_trace_capture #(
  parameter int NBIT_DATA = 32,
  parameter int NLANE     = 2,
  parameter int DEPTH     = 8,
  parameter int CNT_W     = 32
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       arm_i,
  input  logic                       abort_i,
  input  logic [CNT_W-1:0]           nsamples_i,
  input  logic [NLANE-1:0]           commit_valid_i,
  input  logic [NLANE*NBIT_DATA-1:0] commit_data_i,
  output logic [NBIT_DATA-1:0]       misr_data_o,
  output logic                       misr_en_o,
  output logic                       busy_o,
  output logic                       done_o,
  output logic                       overflow_o,
  output logic [CNT_W-1:0]           sample_count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_L = (AW+1)'(DEPTH);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_CAPTURE = 2'd1;
  localparam logic [1:0] S_DRAIN   = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

  logic [1:0]           state_r;
  logic [CNT_W-1:0]     target_r;
  logic [CNT_W-1:0]     count_r;
  logic                 overflow_r;
  logic                 busy_r;
  logic                 done_r;
  logic                 misr_en_r;
  logic [NBIT_DATA-1:0] misr_data_r;
  logic [AW-1:0]        wr_ptr_r;
  logic [AW-1:0]        rd_ptr_r;
  logic [AW:0]          occ_r;
  logic [NBIT_DATA-1:0] mem_r [DEPTH];

  logic [CNT_W-1:0]     remaining_s;
  logic [CNT_W-1:0]     taken_s;
  logic [AW:0]          free_s;
  logic [AW:0]          n_push_s;
  logic [NLANE-1:0]     push_s;
  logic [AW-1:0]        slot_s [NLANE];
  logic                 drop_s;
  logic                 pop_s;
  logic                 arm_ok_s;
  logic [1:0]           state_nxt_s;

  // Lane selection: take lanes in order up to the remaining budget; push while the
  // free space seen at cycle start lasts, drop the rest.
  always_comb begin
    remaining_s = target_r - count_r;
    free_s      = FULL_L - occ_r;
    taken_s     = {CNT_W{1'b0}};
    n_push_s    = {(AW+1){1'b0}};
    push_s      = {NLANE{1'b0}};
    drop_s      = 1'b0;
    for (int k = 0; k < NLANE; k++) begin
      slot_s[k] = wr_ptr_r + n_push_s[AW-1:0];
      if ((state_r == S_CAPTURE) && commit_valid_i[k] && (taken_s < remaining_s)) begin
        taken_s = taken_s + CNT_W'(1'b1);
        if (n_push_s < free_s) begin
          push_s[k] = 1'b1;
          n_push_s  = n_push_s + (AW+1)'(1'b1);
        end else begin
          drop_s = 1'b1;
        end
      end else begin
        push_s[k] = 1'b0;
      end
    end
  end

  // Next-state decode; abort overrides everything, arm only from IDLE/DONE.
  always_comb begin
    pop_s       = (occ_r != {(AW+1){1'b0}});
    arm_ok_s    = arm_i && !abort_i && ((state_r == S_IDLE) || (state_r == S_DONE));
    state_nxt_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (arm_ok_s) state_nxt_s = S_CAPTURE;
        else          state_nxt_s = S_IDLE;
      end
      S_CAPTURE: begin
        if ((count_r + taken_s) == target_r) state_nxt_s = S_DRAIN;
        else                                 state_nxt_s = S_CAPTURE;
      end
      S_DRAIN: begin
        if (!pop_s && !misr_en_r) state_nxt_s = S_DONE;
        else                      state_nxt_s = S_DRAIN;
      end
      S_DONE: begin
        if (arm_ok_s) state_nxt_s = S_CAPTURE;
        else          state_nxt_s = S_DONE;
      end
      default: state_nxt_s = S_IDLE;
    endcase
    if (abort_i) begin
      state_nxt_s = S_IDLE;
    end else begin
      state_nxt_s = state_nxt_s;
    end
  end

  // Control, FIFO bookkeeping and output register.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_r     <= S_IDLE;
      target_r    <= {CNT_W{1'b0}};
      count_r     <= {CNT_W{1'b0}};
      overflow_r  <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      misr_en_r   <= 1'b0;
      misr_data_r <= {NBIT_DATA{1'b0}};
      wr_ptr_r    <= {AW{1'b0}};
      rd_ptr_r    <= {AW{1'b0}};
      occ_r       <= {(AW+1){1'b0}};
    end else begin
      state_r <= state_nxt_s;
      busy_r  <= (state_nxt_s == S_CAPTURE) || (state_nxt_s == S_DRAIN);
      done_r  <= (state_nxt_s == S_DONE);
      if (abort_i || arm_ok_s) begin
        wr_ptr_r  <= {AW{1'b0}};
        rd_ptr_r  <= {AW{1'b0}};
        occ_r     <= {(AW+1){1'b0}};
        misr_en_r <= 1'b0;
        if (arm_ok_s) begin
          target_r   <= nsamples_i;
          count_r    <= {CNT_W{1'b0}};
          overflow_r <= 1'b0;
        end
      end else begin
        wr_ptr_r <= wr_ptr_r + n_push_s[AW-1:0];
        rd_ptr_r <= rd_ptr_r + AW'(pop_s);
        occ_r    <= occ_r + n_push_s - (AW+1)'(pop_s);
        count_r  <= count_r + taken_s;
        if (drop_s) overflow_r <= 1'b1;
        misr_en_r <= pop_s;
        if (pop_s) misr_data_r <= mem_r[rd_ptr_r];
      end
    end
  end

  // FIFO storage; stale writes after a flush are never read.
  always_ff @(posedge clk_i) begin
    for (int k = 0; k < NLANE; k++) begin
      if (push_s[k]) mem_r[slot_s[k]] <= commit_data_i[k*NBIT_DATA +: NBIT_DATA];
    end
  end

  assign misr_data_o    = misr_data_r;
  assign misr_en_o      = misr_en_r;
  assign busy_o         = busy_r;
  assign done_o         = done_r;
  assign overflow_o     = overflow_r;
  assign sample_count_o = count_r;

endmodule

// File: tb/tb_misr_trace_capture.sv
// Bench for misr_trace_capture: directed scenarios plus random traffic, checked
// every cycle against a queue-based reference model.
module tb_misr_trace_capture;
  localparam int NBIT_DATA = 32;
  localparam int NLANE     = 2;
  localparam int DEPTH     = 8;
  localparam int CNT_W     = 32;

  localparam int M_IDLE = 0, M_CAP = 1, M_DRAIN = 2, M_DONE = 3;

  logic                       clk = 1'b0;
  logic                       rst_ni;
  logic                       arm_i;
  logic                       abort_i;
  logic [CNT_W-1:0]           nsamples_i;
  logic [NLANE-1:0]           commit_valid_i;
  logic [NLANE*NBIT_DATA-1:0] commit_data_i;
  logic [NBIT_DATA-1:0]       misr_data_o;
  logic                       misr_en_o;
  logic                       busy_o;
  logic                       done_o;
  logic                       overflow_o;
  logic [CNT_W-1:0]           sample_count_o;

  always #5 clk = ~clk;

  misr_trace_capture #(
    .NBIT_DATA(NBIT_DATA), .NLANE(NLANE), .DEPTH(DEPTH), .CNT_W(CNT_W)
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni), .arm_i(arm_i), .abort_i(abort_i),
    .nsamples_i(nsamples_i), .commit_valid_i(commit_valid_i),
    .commit_data_i(commit_data_i), .misr_data_o(misr_data_o),
    .misr_en_o(misr_en_o), .busy_o(busy_o), .done_o(done_o),
    .overflow_o(overflow_o), .sample_count_o(sample_count_o)
  );

  int n_vec = 0;
  int n_err = 0;
  int n_pulse = 0;

  // reference model state
  int          m_state;
  logic [31:0] m_target, m_count, m_data;
  bit          m_ovf, m_en;
  logic [31:0] m_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step();
    int occ0;
    int room;
    bit en_prev;
    if (!rst_ni) begin
      m_state = M_IDLE; m_target = 0; m_count = 0; m_ovf = 0;
      m_en = 0; m_data = 0; m_q.delete();
    end else if (abort_i) begin
      m_state = M_IDLE; m_q.delete(); m_en = 0;
    end else if (arm_i && (m_state == M_IDLE || m_state == M_DONE)) begin
      m_state = M_CAP; m_target = nsamples_i; m_count = 0; m_ovf = 0;
      m_q.delete(); m_en = 0;
    end else begin
      occ0 = m_q.size();
      room = DEPTH - occ0;
      en_prev = m_en;
      if (occ0 > 0) begin
        m_data = m_q.pop_front();
        m_en = 1;
      end else begin
        m_en = 0;
      end
      if (m_state == M_CAP) begin
        for (int k = 0; k < NLANE; k++) begin
          if (commit_valid_i[k] && m_count < m_target) begin
            m_count++;
            if (room > 0) begin
              m_q.push_back(commit_data_i[k*NBIT_DATA +: NBIT_DATA]);
              room--;
            end else begin
              m_ovf = 1;
            end
          end
        end
        if (m_count == m_target) m_state = M_DRAIN;
      end else if (m_state == M_DRAIN && occ0 == 0 && !en_prev) begin
        m_state = M_DONE;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    if (misr_en_o) n_pulse++;
    check("misr_en", misr_en_o, m_en);
    check("misr_data", misr_data_o, m_data);
    check("busy", busy_o, (m_state == M_CAP || m_state == M_DRAIN));
    check("done", done_o, (m_state == M_DONE));
    check("overflow", overflow_o, m_ovf);
    check("sample_count", sample_count_o, m_count);
    arm_i = 1'b0; abort_i = 1'b0; commit_valid_i = '0; rst_ni = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic arm(input logic [31:0] ns);
    arm_i = 1'b1; nsamples_i = ns; step();
  endtask

  task automatic commit(input logic [1:0] v, input logic [31:0] d0, input logic [31:0] d1);
    commit_valid_i = v; commit_data_i = {d1, d0}; step();
  endtask

  initial begin
    rst_ni = 1'b0; arm_i = 1'b0; abort_i = 1'b0; nsamples_i = '0;
    commit_valid_i = '0; commit_data_i = '0;
    step();
    rst_ni = 1'b0; step();
    check("reset_en", misr_en_o, 1'b0);
    check("reset_count", sample_count_o, 32'd0);

    // 1: four words on lane 0
    arm(32'd4);
    n_pulse = 0;
    for (int i = 1; i <= 4; i++) commit(2'b01, 32'(i), 32'hDEAD);
    idle(12);
    check("t1_pulses", 32'(n_pulse), 32'd4);
    check("t1_count", sample_count_o, 32'd4);
    check("t1_done", done_o, 1'b1);

    // 2: budget cuts off lane 1 of the second cycle
    arm(32'd3);
    commit(2'b11, 32'hA, 32'hB);
    commit(2'b11, 32'hC, 32'hD);
    idle(10);
    check("t2_count", sample_count_o, 32'd3);
    check("t2_done", done_o, 1'b1);

    // 3: overflow
    arm(32'd20);
    n_pulse = 0;
    for (int i = 0; i < 10; i++) commit(2'b11, 32'(100 + 2*i), 32'(101 + 2*i));
    idle(15);
    check("t3_overflow", overflow_o, 1'b1);
    check("t3_count", sample_count_o, 32'd20);
    check("t3_fewer", 32'(n_pulse < 20), 32'd1);
    check("t3_done", done_o, 1'b1);

    // 4: zero-length window
    arm(32'd0);
    n_pulse = 0;
    idle(6);
    check("t4_pulses", 32'(n_pulse), 32'd0);
    check("t4_done", done_o, 1'b1);

    // 5: abort with words buffered, then re-arm
    arm(32'd20);
    for (int i = 0; i < 4; i++) commit(2'b11, 32'(200 + 2*i), 32'(201 + 2*i));
    check("t5_buffered", 32'(m_q.size()), 32'd5);
    abort_i = 1'b1; step();
    n_pulse = 0;
    idle(4);
    check("t5_no_pulse", 32'(n_pulse), 32'd0);
    check("t5_busy", busy_o, 1'b0);
    arm(32'd2);
    check("t5_ovf_clr", overflow_o, 1'b0);
    n_pulse = 0;
    commit(2'b01, 32'h55, 32'h0);
    commit(2'b01, 32'h66, 32'h0);
    idle(8);
    check("t5_pulses", 32'(n_pulse), 32'd2);

    // 6: reset mid-DRAIN
    arm(32'd16);
    for (int i = 0; i < 8; i++) commit(2'b11, 32'(300 + 2*i), 32'(301 + 2*i));
    begin
      int budget;
      budget = 50;
      while (m_state != M_DRAIN && budget > 0) begin
        step();
        budget--;
      end
      check("t6_reach_drain", 32'(budget > 0), 32'd1);
    end
    rst_ni = 1'b0; step();
    check("t6_en", misr_en_o, 1'b0);
    check("t6_busy", busy_o, 1'b0);
    check("t6_data", misr_data_o, 32'd0);
    idle(3);

    // random traffic
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 15) == 0) begin
        arm_i = 1'b1;
        nsamples_i = 32'($urandom_range(0, 24));
      end
      if ($urandom_range(0, 39) == 0) abort_i = 1'b1;
      if ($urandom_range(0, 199) == 0) rst_ni = 1'b0;
      commit_valid_i = 2'($urandom_range(0, 3));
      commit_data_i = {$urandom, $urandom};
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
